// File: rtl/layer3_fetch_pkg.sv
// Shared types and constants for the layer-3 window fetcher.
// Optional macro: LAYER3_FETCH_PAD_EN selects SAME-padded traversal
// (196 windows); without it the VALID traversal (144 windows) is built.
`ifndef LAYER2_OUTPUT_LENGTH
`define LAYER2_OUTPUT_LENGTH 128
`endif

package layer3_fetch_pkg;

  localparam int MAP_W  = 14;
  localparam int K      = 3;
  localparam int DATA_W = `LAYER2_OUTPUT_LENGTH;

`ifdef LAYER3_FETCH_PAD_EN
  localparam int OUT_MAX = MAP_W - 1;
`else
  localparam int OUT_MAX = MAP_W - K;
`endif

  localparam int OUT_W         = OUT_MAX + 1;
  localparam int PIX_PER_FRAME = OUT_W * OUT_W * K * K;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  // One buffered window pixel together with its framing tags.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              win_last;
    logic              frame_last;
  } fifo_entry_t;

endpackage

// File: rtl/layer3_fetch_fifo2.sv
// Two-entry output buffer with occupancy count. Slot 0 is always the head.
// The producer never pushes when full and the consumer never pops when
// empty, so neither case is handled here.
module layer3_fetch_fifo2
  import layer3_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t head,
  output logic [1:0]  count
);

  fifo_entry_t slot [2];

  // Storage and count update; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      count   <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot[0] <= din;
          else               slot[1] <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot[0] <= slot[1];
          count   <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot[0] <= din;
          end else begin
            slot[0] <= slot[1];
            slot[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot[0];

endmodule

// File: rtl/layer3_window_fetch.sv
// Read-side sequencer for the layer-2 result store: walks every 3x3 window
// in raster order, issues store reads and streams the returned pixels to
// layer 3 over valid/ready. Optional macro: LAYER3_FETCH_PAD_EN (SAME
// padding, out-of-map taps become zero pixels without a store read).
module layer3_window_fetch
  import layer3_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       read_row_addr,
  output logic [15:0]       read_col_addr,
  output logic              layer2_result_read_signal,
  input  logic [DATA_W-1:0] layer2_result_output,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_win_last,
  output logic              pix_frame_last
);

  localparam logic [3:0] OMAX = 4'(OUT_MAX);
  localparam logic [1:0] KMAX = 2'(K - 1);

  fetch_state_t state, state_next;

  logic [3:0]  oy, ox;
  logic [1:0]  ky, kx;
  logic        inflight;
  logic        tag_win_last, tag_frame_last;
  logic [1:0]  fifo_count;
  fifo_entry_t fifo_head, fifo_din;
  logic        step, pop, win_end, frame_end;

  assign win_end   = (ky == KMAX) && (kx == KMAX);
  assign frame_end = win_end && (oy == OMAX) && (ox == OMAX);

  // A slot is taken only if the FIFO can hold everything already in flight.
  assign step = (state == RUN) && (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
  assign pop  = pix_valid & pix_ready;

`ifdef LAYER3_FETCH_PAD_EN
  logic [4:0] tap_row, tap_col;
  logic       tap_in_map;
  logic       pend_zero;

  // Taps sit one pixel up/left of the window origin; -1 wraps to 31 and
  // therefore falls outside the map like any other out-of-range tap.
  assign tap_row    = {1'b0, oy} + {3'b000, ky} - 5'd1;
  assign tap_col    = {1'b0, ox} + {3'b000, kx} - 5'd1;
  assign tap_in_map = (tap_row < 5'(MAP_W)) && (tap_col < 5'(MAP_W));

  assign layer2_result_read_signal = step & tap_in_map;
  assign read_row_addr             = {11'd0, tap_row};
  assign read_col_addr             = {11'd0, tap_col};

  // Remembers that the slot in flight is a padding zero, not a store read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_zero <= 1'b0;
    else     pend_zero <= step & ~tap_in_map;
  end

  assign fifo_din.data = pend_zero ? '0 : layer2_result_output;
`else
  assign layer2_result_read_signal = step;
  assign read_row_addr             = {12'd0, oy + {2'b00, ky}};
  assign read_col_addr             = {12'd0, ox + {2'b00, kx}};
  assign fifo_din.data             = layer2_result_output;
`endif

  assign fifo_din.win_last   = tag_win_last;
  assign fifo_din.frame_last = tag_frame_last;

  // Window/tap counters, kx innermost; they wrap back to zero after the
  // final slot so the next frame starts at window (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
    end else if (step) begin
      if (kx != KMAX) begin
        kx <= kx + 2'd1;
      end else begin
        kx <= '0;
        if (ky != KMAX) begin
          ky <= ky + 2'd1;
        end else begin
          ky <= '0;
          if (ox != OMAX) begin
            ox <= ox + 4'd1;
          end else begin
            ox <= '0;
            oy <= (oy != OMAX) ? oy + 4'd1 : 4'd0;
          end
        end
      end
    end
  end

  // One-deep return pipeline matching the store's read latency; the tags
  // travel with the slot so they line up with the returned data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight       <= 1'b0;
      tag_win_last   <= 1'b0;
      tag_frame_last <= 1'b0;
    end else begin
      inflight <= step;
      if (step) begin
        tag_win_last   <= win_end;
        tag_frame_last <= frame_end;
      end
    end
  end

  layer3_fetch_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   (fifo_din),
    .pop   (pop),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign pix_valid      = (fifo_count != 2'd0);
  assign pix_data       = fifo_head.data;
  assign pix_win_last   = pix_valid & fifo_head.win_last;
  assign pix_frame_last = pix_valid & fifo_head.frame_last;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and status outputs; DRAIN leaves in the cycle of the final
  // handshake so that done follows it directly.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (step && frame_end) state_next = DRAIN;
      DRAIN:   if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)))
                 state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer3_window_fetch.sv
// Self-checking bench for layer3_window_fetch: a behavioural store model,
// a window-order reference queue and one per-cycle compare process.
// Honours LAYER3_FETCH_PAD_EN when it is defined for the build.
module tb_layer3_window_fetch;
  import layer3_fetch_pkg::*;

`ifdef LAYER3_FETCH_PAD_EN
  localparam int PAD_OFF = 1;
`else
  localparam int PAD_OFF = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done;
  logic [15:0]       read_row_addr, read_col_addr;
  logic              layer2_result_read_signal;
  logic [DATA_W-1:0] layer2_result_output;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid, pix_ready;
  logic              pix_win_last, pix_frame_last;

  layer3_window_fetch dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .busy                      (busy),
    .done                      (done),
    .read_row_addr             (read_row_addr),
    .read_col_addr             (read_col_addr),
    .layer2_result_read_signal (layer2_result_read_signal),
    .layer2_result_output      (layer2_result_output),
    .pix_data                  (pix_data),
    .pix_valid                 (pix_valid),
    .pix_ready                 (pix_ready),
    .pix_win_last              (pix_win_last),
    .pix_frame_last            (pix_frame_last)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [MAP_W][MAP_W];

  // Store model with one-cycle registered read.
  always @(posedge clk) begin
    if (layer2_result_read_signal) begin
      if (read_row_addr < 16'(MAP_W) && read_col_addr < 16'(MAP_W))
        layer2_result_output <= mem[read_row_addr][read_col_addr];
      else
        layer2_result_output <= '0;
    end
  end

  fifo_entry_t exp_px[$];
  logic [31:0] exp_rd[$];
  int total = 0, bad = 0;
  int cyc = 0, issued = 0, popped = 0, npix = 0, nreads = 0, ndone = 0, last_hs = -10;
  bit rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DATA_W+1:0] act, input logic [DATA_W+1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference traversal straight from the window rules.
  task automatic build_model();
    int r, c;
    logic wl, fl, inb;
    logic [DATA_W-1:0] v;
    exp_px.delete();
    exp_rd.delete();
    issued = 0; popped = 0; npix = 0; nreads = 0;
    for (int oy = 0; oy <= OUT_MAX; oy++)
      for (int ox = 0; ox <= OUT_MAX; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            r   = oy + ky - PAD_OFF;
            c   = ox + kx - PAD_OFF;
            wl  = (ky == K - 1) && (kx == K - 1);
            fl  = wl && (oy == OUT_MAX) && (ox == OUT_MAX);
            inb = (r >= 0) && (r < MAP_W) && (c >= 0) && (c < MAP_W);
            v   = inb ? mem[r][c] : '0;
            exp_px.push_back('{data: v, win_last: wl, frame_last: fl});
            if (inb) exp_rd.push_back({16'(r), 16'(c)});
          end
  endtask

  // Per-cycle comparison of reads, pixels and done against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (layer2_result_read_signal) begin
        if (exp_rd.size() == 0) chk("extra_read", 1'b1, 1'b0);
        else chk("read_addr", {read_row_addr, read_col_addr}, exp_rd.pop_front());
`ifndef LAYER3_FETCH_PAD_EN
        chk("issue_gate_ok", (issued - popped) < 2, 1'b1);
`endif
        issued++;
        nreads++;
      end
      if (pix_valid) begin
        if (exp_px.size() == 0) chk("extra_pixel", 1'b1, 1'b0);
        else chk("pixel", {pix_data, pix_win_last, pix_frame_last},
                 {exp_px[0].data, exp_px[0].win_last, exp_px[0].frame_last});
        if (pix_ready) begin
          if (exp_px.size() != 0) void'(exp_px.pop_front());
          popped++;
          npix++;
          last_hs = cyc;
        end
      end
      if (done) begin
        chk("done_after_last_hs", cyc, last_hs + 1);
        chk("done_all_pixels", npix, PIX_PER_FRAME);
        ndone++;
      end
    end
  end

  // Randomised or constant consumer readiness.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic run_frame(input string name, input int restart_at, input int reset_at);
    int  base_done = ndone;
    bit  finished  = 0;
    bit  restarted = 0;
    bit  was_reset = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
    chk("latency_c1_valid", pix_valid, 1'b0);
    @(negedge clk);
    chk("latency_c2_valid", pix_valid, 1'b0);
    @(negedge clk);
    chk("latency_c3_valid", pix_valid, 1'b1);
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (ndone > base_done) begin finished = 1; break; end
      if (restart_at >= 0 && !restarted && npix >= restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (reset_at >= 0 && npix >= reset_at) begin
        rst = 1'b1;
        was_reset = 1;
        break;
      end
    end
    if (was_reset) begin
      @(negedge clk);
      chk("rst_ctrl_zero", {busy, done, layer2_result_read_signal, pix_valid,
                            pix_win_last, pix_frame_last}, '0);
      chk("rst_addr_zero", {read_row_addr, read_col_addr}, '0);
      chk("rst_data_zero", pix_data, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_done", ndone, base_done);
      chk("rst_idle", busy, 1'b0);
    end else begin
      chk("frame_done_seen", finished, 1'b1);
      chk("frame_pixels", npix, PIX_PER_FRAME);
      chk("frame_reads_left", exp_rd.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("single_done", ndone, base_done + 1);
      chk("idle_after_done", busy, 1'b0);
    end
    $display("frame %s: pixels=%0d reads=%0d reset=%0d done_pulses=%0d",
             name, npix, nreads, was_reset, ndone - base_done);
  endtask

  initial begin
    int lit [9];
    rst   = 1'b1;
    start = 1'b0;
    for (int r = 0; r < MAP_W; r++)
      for (int c = 0; c < MAP_W; c++)
        mem[r][c] = DATA_W'(r * 14 + c);
    build_model();

`ifdef LAYER3_FETCH_PAD_EN
    lit = '{0, 0, 0, 0, 0, 1, 0, 14, 15};
    chk("model_size", exp_px.size(), 1764);
`else
    lit = '{0, 1, 2, 14, 15, 16, 28, 29, 30};
    chk("model_size", exp_px.size(), 1296);
`endif
    for (int i = 0; i < 9; i++) chk("model_first_win", exp_px[i].data, DATA_W'(lit[i]));
    chk("model_win_last_8", exp_px[8].win_last, 1'b1);
    chk("model_win_last_7", exp_px[7].win_last, 1'b0);
    chk("model_last_read", exp_rd[exp_rd.size() - 1], {16'd13, 16'd13});
    chk("model_frame_last", exp_px[exp_px.size() - 1].frame_last, 1'b1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_read", layer2_result_read_signal, 1'b0);
    chk("reset_valid", pix_valid, 1'b0);

    run_frame("linear_ready_high", -1, -1);

    for (int r = 0; r < MAP_W; r++)
      for (int c = 0; c < MAP_W; c++)
        mem[r][c] = {$urandom, $urandom, $urandom, $urandom};
    rand_ready = 1;
    build_model();
    run_frame("random_ready_restart_at_500", 500, -1);

    build_model();
    run_frame("second_start_after_done", -1, -1);

    build_model();
    run_frame("reset_at_700", -1, 700);

    build_model();
    run_frame("after_reset", -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
